// File: rtl/wb_port_scheduler_if.sv
// Register-file write-port bundle: pipeline WB, late-load issue/response,
// decode hazard checks and the registered register-file write.
interface wb_port_scheduler_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 4
);
  logic              pipe_we;
  logic [REG_AW-1:0] pipe_waddr;
  logic [DATA_W-1:0] pipe_wdata;
  logic              ld_issue;
  logic [REG_AW-1:0] ld_dest;
  logic              ld_issue_ready;
  logic              ld_rsp_valid;
  logic [DATA_W-1:0] ld_rsp_data;
  logic              ld_rsp_ready;
  logic              chk_a_en;
  logic [REG_AW-1:0] chk_a_addr;
  logic              chk_b_en;
  logic [REG_AW-1:0] chk_b_addr;
  logic              chk_w_en;
  logic [REG_AW-1:0] chk_w_addr;
  logic              hazard_stall;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  modport master (
    output pipe_we, pipe_waddr, pipe_wdata,
    output ld_issue, ld_dest, ld_rsp_valid, ld_rsp_data,
    output chk_a_en, chk_a_addr, chk_b_en, chk_b_addr, chk_w_en, chk_w_addr,
    input  ld_issue_ready, ld_rsp_ready, hazard_stall,
    input  rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  pipe_we, pipe_waddr, pipe_wdata,
    input  ld_issue, ld_dest, ld_rsp_valid, ld_rsp_data,
    input  chk_a_en, chk_a_addr, chk_b_en, chk_b_addr, chk_w_en, chk_w_addr,
    output ld_issue_ready, ld_rsp_ready, hazard_stall,
    output rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/wb_port_scheduler.sv
// Shares the single register-file write port between the pipeline WB stage
// (fixed priority) and in-order late load responses that fill idle cycles.
module wb_port_scheduler #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned REG_AW    = 4,
  parameter int unsigned TAG_DEPTH = 4
) (
  input logic                 clk,
  input logic                 rst,
  wb_port_scheduler_if.slave  bus
);

  localparam int unsigned PtrW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned NReg = 1 << REG_AW;

  logic [REG_AW-1:0] tag_q [TAG_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic              hold_valid_q;
  logic [REG_AW-1:0] hold_addr_q;
  logic [DATA_W-1:0] hold_data_q;
  logic [NReg-1:0]   pending_q, pending_d;

  logic full, empty, drain, push, pop;

  always_comb begin
    full  = (count_q == CntW'(TAG_DEPTH));
    empty = (count_q == '0);
    drain = hold_valid_q & ~bus.pipe_we;

    // Readiness and stall are forced low while reset is held.
    bus.ld_issue_ready = ~rst & ~full & ~pending_q[bus.ld_dest];
    bus.ld_rsp_ready   = ~rst & ~empty & (~hold_valid_q | drain);
    push = bus.ld_issue & bus.ld_issue_ready;
    pop  = bus.ld_rsp_valid & bus.ld_rsp_ready;

    bus.hazard_stall = ~rst & ((bus.chk_a_en & pending_q[bus.chk_a_addr]) |
                               (bus.chk_b_en & pending_q[bus.chk_b_addr]) |
                               (bus.chk_w_en & pending_q[bus.chk_w_addr]));

    // Set and clear never hit the same bit: issue to a pending register is refused.
    pending_d = pending_q;
    if (drain) pending_d[hold_addr_q] = 1'b0;
    if (push)  pending_d[bus.ld_dest] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) tag_q[wr_ptr_q] <= bus.ld_dest;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      hold_valid_q <= 1'b0;
      hold_addr_q  <= '0;
      hold_data_q  <= '0;
      pending_q    <= '0;
      bus.rf_we    <= 1'b0;
      bus.rf_waddr <= '0;
      bus.rf_wdata <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(push) - CntW'(pop);

      if (pop) begin
        hold_valid_q <= 1'b1;
        hold_addr_q  <= tag_q[rd_ptr_q];
        hold_data_q  <= bus.ld_rsp_data;
      end else if (drain) begin
        hold_valid_q <= 1'b0;
      end

      pending_q <= pending_d;

      if (bus.pipe_we) begin
        bus.rf_we    <= 1'b1;
        bus.rf_waddr <= bus.pipe_waddr;
        bus.rf_wdata <= bus.pipe_wdata;
      end else if (hold_valid_q) begin
        bus.rf_we    <= 1'b1;
        bus.rf_waddr <= hold_addr_q;
        bus.rf_wdata <= hold_data_q;
      end else begin
        bus.rf_we <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_scheduler.sv
// Directed bench: expected register-file writes are queued as stimulus is driven
// and popped as the DUT writes them; combinational outputs are checked inline.
module tb_wb_port_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_port_scheduler_if #(.DATA_W(16), .REG_AW(4)) bus ();

  wb_port_scheduler #(.DATA_W(16), .REG_AW(4), .TAG_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [19:0] pipe_q [$];
  logic [19:0] load_q [$];
  logic [3:0]  tag_q  [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic pend_has(input logic [3:0] a);
    logic hit = 1'b0;
    foreach (tag_q[i]) if (tag_q[i] == a) hit = 1'b1;
    foreach (load_q[i]) if (load_q[i][19:16] == a) hit = 1'b1;
    return hit;
  endfunction

  // Advance one edge, drop strobes, and score any register-file write.
  task automatic step();
    logic        pw;
    logic [19:0] e;
    pw = bus.pipe_we;
    @(posedge clk);
    #1;
    bus.pipe_we      = 1'b0;
    bus.ld_issue     = 1'b0;
    bus.ld_rsp_valid = 1'b0;
    if (pw) chk("rf_we_pipe", {31'd0, bus.rf_we}, 1);
    if (bus.rf_we) begin
      if (pw) begin
        e = pipe_q.pop_front();
      end else if (load_q.size() > 0) begin
        e = load_q.pop_front();
      end else begin
        chk("rf_spurious", {31'd0, bus.rf_we}, 0);
        return;
      end
      chk("rf_write", {12'd0, bus.rf_waddr, bus.rf_wdata}, {12'd0, e});
    end
  endtask

  task automatic issue(input logic [3:0] d, input logic exp_rdy);
    bus.ld_issue = 1'b1;
    bus.ld_dest  = d;
    #1;
    chk("issue_ready", {31'd0, bus.ld_issue_ready}, {31'd0, exp_rdy});
    if (exp_rdy) tag_q.push_back(d);
  endtask

  task automatic rsp(input logic [15:0] d, input logic exp_rdy);
    bus.ld_rsp_valid = 1'b1;
    bus.ld_rsp_data  = d;
    #1;
    chk("rsp_ready", {31'd0, bus.ld_rsp_ready}, {31'd0, exp_rdy});
    if (exp_rdy && tag_q.size() > 0) load_q.push_back({tag_q.pop_front(), d});
  endtask

  task automatic pipe(input logic [3:0] a, input logic [15:0] d);
    chk("proto_pipe_to_pending", {31'd0, pend_has(a)}, 0);
    bus.pipe_we    = 1'b1;
    bus.pipe_waddr = a;
    bus.pipe_wdata = d;
    pipe_q.push_back({a, d});
  endtask

  task automatic hz(input string tag, input logic exp);
    #1;
    chk(tag, {31'd0, bus.hazard_stall}, {31'd0, exp});
  endtask

  initial begin
    logic any_hz;
    logic [3:0] d;
    bus.pipe_we = 0; bus.pipe_waddr = 0; bus.pipe_wdata = 0;
    bus.ld_issue = 0; bus.ld_dest = 0; bus.ld_rsp_valid = 0; bus.ld_rsp_data = 0;
    bus.chk_a_en = 0; bus.chk_a_addr = 0; bus.chk_b_en = 0; bus.chk_b_addr = 0;
    bus.chk_w_en = 0; bus.chk_w_addr = 0;

    // Reset: outputs quiet while held, rf cleared after
    bus.ld_issue = 1; bus.ld_rsp_valid = 1; bus.chk_a_en = 1;
    #1;
    chk("rst_issue_ready", {31'd0, bus.ld_issue_ready}, 0);
    chk("rst_rsp_ready", {31'd0, bus.ld_rsp_ready}, 0);
    chk("rst_hazard", {31'd0, bus.hazard_stall}, 0);
    step();
    step();
    rst = 1'b0;
    bus.chk_a_en = 0;
    chk("rst_rf_we", {31'd0, bus.rf_we}, 0);
    chk("rst_rf_waddr", {28'd0, bus.rf_waddr}, 0);
    chk("rst_rf_wdata", {16'd0, bus.rf_wdata}, 0);

    // Single load to r3, pipeline idle
    issue(4'd3, 1);
    step();
    bus.chk_a_en = 1; bus.chk_a_addr = 4'd3;
    hz("hz_r3_pending", 1);
    rsp(16'hBEEF, 1);
    step();
    hz("hz_r3_in_hold", 1);
    step();
    chk("r3_rf_we", {31'd0, bus.rf_we}, 1);
    chk("r3_rf_waddr", {28'd0, bus.rf_waddr}, 3);
    chk("r3_rf_wdata", {16'd0, bus.rf_wdata}, 32'hBEEF);
    hz("hz_r3_cleared", 0);
    bus.chk_a_en = 0;

    // Response parked in hold while the pipeline writes r1 three cycles
    issue(4'd7, 1); step();
    issue(4'd8, 1); step();
    pipe(4'd1, 16'h0011); rsp(16'h7777, 1); step();
    pipe(4'd1, 16'h0011); rsp(16'h8888, 0); step();
    pipe(4'd1, 16'h0011); rsp(16'h8888, 0); step();
    rsp(16'h8888, 1); step();
    chk("hold_r7_rf_we", {31'd0, bus.rf_we}, 1);
    step();
    chk("hold_r8_rf_we", {31'd0, bus.rf_we}, 1);

    // Four back-to-back issues fill the FIFO, then one response per cycle
    issue(4'd1, 1); step();
    issue(4'd2, 1); step();
    issue(4'd4, 1); step();
    issue(4'd5, 1); step();
    bus.chk_b_en = 1; bus.chk_b_addr = 4'd4;
    hz("hz_b_r4", 1);
    bus.chk_b_addr = 4'd3;
    hz("hz_b_r3_clear", 0);
    bus.chk_b_en = 0;
    bus.chk_a_addr = 4'd1;
    hz("hz_a_disabled", 0);
    issue(4'd9, 0); step();
    rsp(16'h1001, 1); step();
    rsp(16'h2002, 1); step();
    chk("b2b_r1_rf_we", {31'd0, bus.rf_we}, 1);
    rsp(16'h4004, 1); step();
    chk("b2b_r2_rf_we", {31'd0, bus.rf_we}, 1);
    rsp(16'h5005, 1); step();
    chk("b2b_r4_rf_we", {31'd0, bus.rf_we}, 1);
    step();
    chk("b2b_r5_rf_we", {31'd0, bus.rf_we}, 1);

    // Second issue to a pending register is refused; WAW check stalls
    issue(4'd6, 1); step();
    issue(4'd6, 0);
    bus.chk_w_en = 1; bus.chk_w_addr = 4'd6;
    hz("hz_waw_r6", 1);
    step();
    rsp(16'h6666, 1); step();
    hz("hz_waw_r6_hold", 1);
    step();
    hz("hz_waw_r6_clear", 0);
    bus.chk_w_en = 0;

    // Reset mid-flight drops outstanding loads
    issue(4'd10, 1); step();
    issue(4'd11, 1); step();
    rst = 1'b1;
    bus.ld_rsp_valid = 1;
    #1;
    chk("midrst_rsp_ready", {31'd0, bus.ld_rsp_ready}, 0);
    step();
    rst = 1'b0;
    tag_q.delete();
    chk("midrst_rf_we", {31'd0, bus.rf_we}, 0);
    any_hz = 1'b0;
    bus.chk_a_en = 1; bus.chk_b_en = 1; bus.chk_w_en = 1;
    for (int a = 0; a < 16; a++) begin
      bus.chk_a_addr = 4'(a); bus.chk_b_addr = 4'(a); bus.chk_w_addr = 4'(a);
      #1;
      any_hz = any_hz | bus.hazard_stall;
    end
    chk("midrst_pending_clear", {31'd0, any_hz}, 0);
    bus.chk_a_en = 0; bus.chk_b_en = 0; bus.chk_w_en = 0;
    rsp(16'hDEAD, 0); step();

    // Full FIFO: simultaneous response accept and issue -> issue refused, then accepted
    issue(4'd1, 1); step();
    issue(4'd2, 1); step();
    issue(4'd3, 1); step();
    issue(4'd4, 1); step();
    rsp(16'hA001, 1); issue(4'd5, 0); step();
    rsp(16'hA002, 1); issue(4'd5, 1); step();
    chk("full_r1_rf_we", {31'd0, bus.rf_we}, 1);
    rsp(16'hA003, 1); step();
    rsp(16'hA004, 1); step();
    rsp(16'hA005, 1); step();
    step();
    chk("full_r5_rf_we", {31'd0, bus.rf_we}, 1);

    // Pointer wrap over ten issue/response pairs
    for (int i = 0; i < 10; i++) begin
      d = 4'((i * 5 + 3) % 16);
      issue(d, 1); step();
      rsp(16'hC000 + 16'(i), 1); step();
    end
    step();

    chk("load_q_drained", load_q.size(), 0);
    chk("pipe_q_drained", pipe_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
